// File: rtl/accel_softreg_ctrl.sv
// accel_softreg_ctrl
//   Soft-register front end for an AMI-attached accelerator. Decodes softreg
//   reads/writes, sequences the accelerator through IDLE/START/RUN/HALT,
//   relocates per-channel memory requests by BASE, enforces a LIMIT window,
//   and runs a watchdog on the RUN cycle count.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   sr_req_*             : softreg request (valid/write/addr/data)
//   sr_resp_valid/data   : read response, one cycle after the read request
//   acc_start, acc_halt  : start pulse / halt level to the accelerator
//   acc_done             : completion pulse from the accelerator
//   acc_req_valid/addr   : per-channel window-relative requests from the core
//   acc_req_grant        : grant back to the core
//   mem_req_valid/addr   : relocated requests to memory
//   mem_req_grant        : grant from memory
module accel_softreg_ctrl #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned REG_ADDR_W = 32,
    parameter int unsigned CNT_W      = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sr_req_valid,
    input  logic                     sr_req_write,
    input  logic [REG_ADDR_W-1:0]    sr_req_addr,
    input  logic [63:0]              sr_req_data,
    output logic                     sr_resp_valid,
    output logic [63:0]              sr_resp_data,
    output logic                     acc_start,
    output logic                     acc_halt,
    input  logic                     acc_done,
    input  logic [NUM_CH-1:0]        acc_req_valid,
    input  logic [NUM_CH*ADDR_W-1:0] acc_req_addr,
    output logic [NUM_CH-1:0]        acc_req_grant,
    output logic [NUM_CH-1:0]        mem_req_valid,
    output logic [NUM_CH*ADDR_W-1:0] mem_req_addr,
    input  logic [NUM_CH-1:0]        mem_req_grant
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam logic [REG_ADDR_W-1:0] AddrCtrl    = REG_ADDR_W'(32'h00);
    localparam logic [REG_ADDR_W-1:0] AddrBase    = REG_ADDR_W'(32'h08);
    localparam logic [REG_ADDR_W-1:0] AddrLimit   = REG_ADDR_W'(32'h10);
    localparam logic [REG_ADDR_W-1:0] AddrTimeout = REG_ADDR_W'(32'h18);
    localparam logic [REG_ADDR_W-1:0] AddrCycles  = REG_ADDR_W'(32'h20);
    localparam int unsigned           ReqCntBase  = 32'h28;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  reqcnt_q [NUM_CH];
    logic [CNT_W-1:0]  reqcnt_d [NUM_CH];
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              tmo_q, tmo_d;
    logic [7:0]        fault_ch_q, fault_ch_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_data_q, resp_data_d;

    logic        wr_en, rd_en, ctrl_wr;
    logic        start_cmd, abort_cmd, clear_cmd;
    logic        in_run;
    logic        fault_hit;
    logic [7:0]  fault_ch_now;
    logic        timeout_hit;
    logic [63:0] rd_data;

    // ------------------------------------------------------------------
    // Softreg command decode
    // ------------------------------------------------------------------
    assign wr_en     = sr_req_valid & sr_req_write;
    assign rd_en     = sr_req_valid & ~sr_req_write;
    assign ctrl_wr   = wr_en && (sr_req_addr == AddrCtrl);
    assign start_cmd = ctrl_wr & sr_req_data[0];
    assign abort_cmd = ctrl_wr & sr_req_data[1];
    assign clear_cmd = ctrl_wr & sr_req_data[2];
    assign in_run    = (state_q == StRun);

    // Bounds check; the lowest faulting channel is reported.
    always_comb begin
        fault_hit    = 1'b0;
        fault_ch_now = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!fault_hit && in_run && (limit_q != '0) && acc_req_valid[c] &&
                (acc_req_addr[c*ADDR_W +: ADDR_W] >= limit_q)) begin
                fault_hit    = 1'b1;
                fault_ch_now = 8'(c);
            end
        end
    end

    // Fires in the RUN cycle that brings CYCLES up to TIMEOUT.
    assign timeout_hit = in_run && (timeout_q != '0) && ((cycles_q + CNT_W'(1)) == timeout_q);

    // ------------------------------------------------------------------
    // Request relocation and gating
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_valid = '0;
        mem_req_addr  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mem_req_addr[c*ADDR_W +: ADDR_W] = acc_req_addr[c*ADDR_W +: ADDR_W] + base_q;
            mem_req_valid[c] = acc_req_valid[c] && in_run && !fault_hit;
        end
    end

    assign acc_req_grant = mem_req_grant & mem_req_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Priority in RUN is fault > timeout > done > abort/clear.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_cmd) state_d = StStart;
            end
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                if (fault_hit || timeout_hit) begin
                    state_d = StHalt;
                end else if (acc_done) begin
                    state_d = StIdle;
                end else if (abort_cmd || clear_cmd) begin
                    state_d = StIdle;
                end
            end
            StHalt: begin
                if (abort_cmd || clear_cmd) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        acc_start = (state_q == StStart);
        acc_halt  = (state_q == StHalt);
    end

    // ------------------------------------------------------------------
    // Registers, sticky status and counters
    // ------------------------------------------------------------------
    always_comb begin
        base_d     = base_q;
        limit_d    = limit_q;
        timeout_d  = timeout_q;
        cycles_d   = cycles_q;
        done_d     = done_q;
        fault_d    = fault_q;
        tmo_d      = tmo_q;
        fault_ch_d = fault_ch_q;
        for (int c = 0; c < NUM_CH; c++) begin
            reqcnt_d[c] = reqcnt_q[c];
        end

        // Window and watchdog configuration is frozen outside IDLE.
        if (wr_en && (state_q == StIdle)) begin
            if (sr_req_addr == AddrBase)    base_d    = sr_req_data[ADDR_W-1:0];
            if (sr_req_addr == AddrLimit)   limit_d   = sr_req_data[ADDR_W-1:0];
            if (sr_req_addr == AddrTimeout) timeout_d = sr_req_data[CNT_W-1:0];
        end

        if (clear_cmd) begin
            done_d     = 1'b0;
            fault_d    = 1'b0;
            tmo_d      = 1'b0;
            fault_ch_d = '0;
        end

        unique case (state_q)
            StStart: begin
                cycles_d   = '0;
                done_d     = 1'b0;
                fault_d    = 1'b0;
                tmo_d      = 1'b0;
                fault_ch_d = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    reqcnt_d[c] = '0;
                end
            end
            StRun: begin
                if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
                // Event bits override a same-cycle clear.
                if (fault_hit) begin
                    fault_d    = 1'b1;
                    fault_ch_d = fault_ch_now;
                end else if (timeout_hit) begin
                    tmo_d = 1'b1;
                end else if (acc_done) begin
                    done_d = 1'b1;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mem_req_valid[c] && mem_req_grant[c] && (reqcnt_q[c] != '1)) begin
                        reqcnt_d[c] = reqcnt_q[c] + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux and response register
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (sr_req_addr)
            AddrCtrl:    rd_data = {48'd0, fault_ch_q, 2'b00, state_q, 1'b0, tmo_q, fault_q, done_q};
            AddrBase:    rd_data = 64'(base_q);
            AddrLimit:   rd_data = 64'(limit_q);
            AddrTimeout: rd_data = 64'(timeout_q);
            AddrCycles:  rd_data = 64'(cycles_q);
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (sr_req_addr == REG_ADDR_W'(ReqCntBase + 32'(c) * 32'd8)) begin
                        rd_data = 64'(reqcnt_q[c]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        resp_valid_d = rd_en;
        resp_data_d  = rd_en ? rd_data : '0;
    end

    assign sr_resp_valid = resp_valid_q;
    assign sr_resp_data  = resp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q       <= '0;
            limit_q      <= '0;
            timeout_q    <= '0;
            cycles_q     <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            tmo_q        <= 1'b0;
            fault_ch_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                reqcnt_q[c] <= '0;
            end
        end else begin
            base_q       <= base_d;
            limit_q      <= limit_d;
            timeout_q    <= timeout_d;
            cycles_q     <= cycles_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            tmo_q        <= tmo_d;
            fault_ch_q   <= fault_ch_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int c = 0; c < NUM_CH; c++) begin
                reqcnt_q[c] <= reqcnt_d[c];
            end
        end
    end

endmodule

// File: tb/tb_accel_softreg_ctrl.sv
// Self-checking bench for accel_softreg_ctrl (NUM_CH=2, 64-bit addresses/counters).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// before the next rising edge.
module tb_accel_softreg_ctrl;

    localparam int NCH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         sr_req_valid, sr_req_write;
    logic [31:0]  sr_req_addr;
    logic [63:0]  sr_req_data;
    logic         sr_resp_valid;
    logic [63:0]  sr_resp_data;
    logic         acc_start, acc_halt, acc_done;
    logic [1:0]   acc_req_valid, acc_req_grant, mem_req_valid, mem_req_grant;
    logic [127:0] acc_req_addr, mem_req_addr;

    int vectors    = 0;
    int miscompares = 0;

    accel_softreg_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .sr_req_valid  (sr_req_valid),
        .sr_req_write  (sr_req_write),
        .sr_req_addr   (sr_req_addr),
        .sr_req_data   (sr_req_data),
        .sr_resp_valid (sr_resp_valid),
        .sr_resp_data  (sr_resp_data),
        .acc_start     (acc_start),
        .acc_halt      (acc_halt),
        .acc_done      (acc_done),
        .acc_req_valid (acc_req_valid),
        .acc_req_addr  (acc_req_addr),
        .acc_req_grant (acc_req_grant),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_grant (mem_req_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

    // STATUS layout: done bit0, fault bit1, timeout bit2, state [5:4], fault channel [15:8].
    function automatic logic [63:0] status_word(input int done, input int fault, input int tmo,
                                                input int st, input int ch);
        return 64'(done + fault * 2 + tmo * 4 + st * 16 + ch * 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sr_req_valid  = 1'b0;
        sr_req_write  = 1'b0;
        sr_req_addr   = '0;
        sr_req_data   = '0;
        acc_done      = 1'b0;
        acc_req_valid = '0;
        acc_req_addr  = '0;
        mem_req_grant = '0;
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        sr_req_valid = 1'b1;
        sr_req_write = 1'b1;
        sr_req_addr  = a;
        sr_req_data  = d;
        tick();
        sr_req_valid = 1'b0;
        sr_req_write = 1'b0;
    endtask

    // Returns X when no response appears, so any later compare flags it.
    task automatic sr_read(input logic [31:0] a, output logic [63:0] d);
        sr_req_valid = 1'b1;
        sr_req_write = 1'b0;
        sr_req_addr  = a;
        tick();
        sr_req_valid = 1'b0;
        d = sr_resp_valid ? sr_resp_data : 'x;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        reset = 1'b1;
        idle_inputs();
        acc_req_valid = 2'b11;
        mem_req_grant = 2'b11;
        tick();
        tick();
        vectors++; if (acc_start !== 1'b0) begin miscompares++; $display("FAIL rst_acc_start: got %b want 0", acc_start); end
        vectors++; if (acc_halt !== 1'b0) begin miscompares++; $display("FAIL rst_acc_halt: got %b want 0", acc_halt); end
        vectors++; if (sr_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", sr_resp_valid); end
        vectors++; if (mem_req_valid !== 2'b00) begin miscompares++; $display("FAIL rst_mem_valid: got %b want 00", mem_req_valid); end
        vectors++; if (acc_req_grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b want 00", acc_req_grant); end
        reset = 1'b0;
        idle_inputs();
        tick();
        for (int i = 0; i < 8; i++) begin
            sr_read(32'(i * 8), d);
            vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL rst_reg_%0h: got %h want 0", i * 8, d); end
        end
    endtask

    task automatic test_relocation();
        logic [63:0] d;
        sr_write(32'h08, 64'h1000);
        sr_write(32'h00, 64'h1);
        vectors++; if (acc_start !== 1'b1) begin miscompares++; $display("FAIL start_pulse_hi: got %b want 1", acc_start); end
        tick();
        vectors++; if (acc_start !== 1'b0) begin miscompares++; $display("FAIL start_pulse_lo: got %b want 0", acc_start); end
        acc_req_valid = 2'b10;
        acc_req_addr[64 +: 64] = 64'h40;
        mem_req_grant = 2'b10;
        #1;
        vectors++; if (mem_req_addr[64 +: 64] !== 64'h1040) begin miscompares++; $display("FAIL reloc_addr1: got %h want 1040", mem_req_addr[64 +: 64]); end
        vectors++; if (mem_req_valid !== 2'b10) begin miscompares++; $display("FAIL reloc_valid: got %b want 10", mem_req_valid); end
        vectors++; if (acc_req_grant !== 2'b10) begin miscompares++; $display("FAIL reloc_grant: got %b want 10", acc_req_grant); end
        tick();
        idle_inputs();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        sr_read(32'h30, d);
        vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL reqcnt1: got %h want 1", d); end
        sr_read(32'h28, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL reqcnt0: got %h want 0", d); end
    endtask

    task automatic test_done();
        logic [63:0] d;
        sr_write(32'h00, 64'h1);
        tick();
        repeat (10) tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        sr_req_valid = 1'b1;
        sr_req_write = 1'b0;
        sr_req_addr  = 32'h00;
        #1;
        vectors++; if (sr_resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_early: got %b want 0", sr_resp_valid); end
        tick();
        sr_req_valid = 1'b0;
        vectors++; if (sr_resp_valid !== 1'b1) begin miscompares++; $display("FAIL resp_latency: got %b want 1", sr_resp_valid); end
        vectors++; if (sr_resp_data !== status_word(1, 0, 0, 0, 0)) begin miscompares++; $display("FAIL done_status: got %h want %h", sr_resp_data, status_word(1, 0, 0, 0, 0)); end
        tick();
        vectors++; if (sr_resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_single: got %b want 0", sr_resp_valid); end
        sr_read(32'h20, d);
        vectors++; if (d !== 64'd11) begin miscompares++; $display("FAIL done_cycles: got %0d want 11", d); end
    endtask

    task automatic test_fault();
        logic [63:0] d;
        sr_write(32'h10, 64'h100);
        sr_write(32'h00, 64'h1);
        tick();
        acc_req_valid = 2'b01;
        acc_req_addr[0 +: 64] = 64'h100;
        mem_req_grant = 2'b11;
        #1;
        vectors++; if (mem_req_valid !== 2'b00) begin miscompares++; $display("FAIL fault_gate: got %b want 00", mem_req_valid); end
        vectors++; if (acc_req_grant !== 2'b00) begin miscompares++; $display("FAIL fault_grant: got %b want 00", acc_req_grant); end
        tick();
        idle_inputs();
        vectors++; if (acc_halt !== 1'b1) begin miscompares++; $display("FAIL fault_halt: got %b want 1", acc_halt); end
        sr_read(32'h00, d);
        vectors++; if (d !== status_word(0, 1, 0, 3, 0)) begin miscompares++; $display("FAIL fault_status: got %h want %h", d, status_word(0, 1, 0, 3, 0)); end
        sr_write(32'h00, 64'h2);
        vectors++; if (acc_halt !== 1'b0) begin miscompares++; $display("FAIL abort_halt: got %b want 0", acc_halt); end
        sr_read(32'h00, d);
        vectors++; if (d !== status_word(0, 1, 0, 0, 0)) begin miscompares++; $display("FAIL abort_status: got %h want %h", d, status_word(0, 1, 0, 0, 0)); end
        sr_write(32'h10, 64'h0);
    endtask

    task automatic test_timeout();
        logic [63:0] d;
        sr_write(32'h18, 64'd5);
        sr_write(32'h00, 64'h1);
        tick();
        repeat (4) tick();
        vectors++; if (acc_halt !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b want 0", acc_halt); end
        tick();
        vectors++; if (acc_halt !== 1'b1) begin miscompares++; $display("FAIL tmo_halt: got %b want 1", acc_halt); end
        sr_read(32'h00, d);
        vectors++; if (d !== status_word(0, 0, 1, 3, 0)) begin miscompares++; $display("FAIL tmo_status: got %h want %h", d, status_word(0, 0, 1, 3, 0)); end
        sr_read(32'h20, d);
        vectors++; if (d !== 64'd5) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 5", d); end
        sr_write(32'h00, 64'h4);
        sr_read(32'h00, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL clear_status: got %h want 0", d); end
        sr_write(32'h18, 64'd0);
    endtask

    task automatic test_config_lock();
        logic [63:0] d;
        sr_write(32'h00, 64'h1);
        tick();
        sr_write(32'h08, 64'hdead);
        sr_write(32'h00, 64'h1);
        vectors++; if (acc_start !== 1'b0) begin miscompares++; $display("FAIL restart_ignored: got %b want 0", acc_start); end
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        sr_read(32'h08, d);
        vectors++; if (d !== 64'h1000) begin miscompares++; $display("FAIL base_locked: got %h want 1000", d); end
        sr_write(32'h20, 64'h55);
        sr_write(32'h38, 64'h77);
        sr_read(32'h20, d);
        vectors++; if (d !== 64'd3) begin miscompares++; $display("FAIL cycles_ro: got %0d want 3", d); end
        sr_read(32'h38, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL unmapped: got %h want 0", d); end
    endtask

    // Random traffic against a model of relocation, gating, counting and bounds.
    task automatic test_random();
        logic [63:0] d, m_base, m_limit, a, m_cnt [NCH], m_cycles;
        logic [1:0]  v, g, exp_valid;
        bit          faulted, fault_now;
        int          ech;

        m_base = {$urandom(), $urandom()};
        sr_write(32'h08, m_base);
        sr_write(32'h00, 64'h1);
        tick();
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        m_cycles = 0;
        for (int i = 0; i < 150; i++) begin
            v = 2'($urandom_range(0, 3));
            g = 2'($urandom_range(0, 3));
            acc_req_valid = v;
            mem_req_grant = g;
            for (int c = 0; c < NCH; c++) acc_req_addr[c*64 +: 64] = {$urandom(), $urandom()};
            #1;
            for (int c = 0; c < NCH; c++) begin
                a = acc_req_addr[c*64 +: 64] + m_base;
                vectors++; if (mem_req_addr[c*64 +: 64] !== a) begin miscompares++; $display("FAIL rnd_addr ch%0d: got %h want %h", c, mem_req_addr[c*64 +: 64], a); end
                if (v[c] && g[c]) m_cnt[c]++;
            end
            vectors++; if (mem_req_valid !== v) begin miscompares++; $display("FAIL rnd_valid: got %b want %b", mem_req_valid, v); end
            vectors++; if (acc_req_grant !== (v & g)) begin miscompares++; $display("FAIL rnd_grant: got %b want %b", acc_req_grant, v & g); end
            m_cycles++;
            tick();
        end
        idle_inputs();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        m_cycles++;
        for (int c = 0; c < NCH; c++) begin
            sr_read(32'(40 + 8 * c), d);
            vectors++; if (d !== m_cnt[c]) begin miscompares++; $display("FAIL rnd_reqcnt%0d: got %0d want %0d", c, d, m_cnt[c]); end
        end
        sr_read(32'h20, d);
        vectors++; if (d !== m_cycles) begin miscompares++; $display("FAIL rnd_cycles: got %0d want %0d", d, m_cycles); end

        // Bounds phase: run random addresses near LIMIT until the first fault.
        m_limit = 64'($urandom_range(32'h100, 32'hf00));
        sr_write(32'h10, m_limit);
        sr_write(32'h00, 64'h1);
        tick();
        faulted = 0;
        ech = 0;
        for (int i = 0; i < 100 && !faulted; i++) begin
            v = 2'($urandom_range(0, 3));
            if (i == 99) v = 2'b10;
            acc_req_valid = v;
            mem_req_grant = 2'($urandom_range(0, 3));
            fault_now = 0;
            for (int c = 0; c < NCH; c++) begin
                a = 64'($urandom_range(0, 32'(m_limit + m_limit / 8)));
                if (i == 99) a = m_limit;
                acc_req_addr[c*64 +: 64] = a;
                if (!fault_now && v[c] && a >= m_limit) begin
                    fault_now = 1;
                    ech = c;
                end
            end
            exp_valid = fault_now ? 2'b00 : v;
            #1;
            vectors++; if (mem_req_valid !== exp_valid) begin miscompares++; $display("FAIL bnd_valid: got %b want %b", mem_req_valid, exp_valid); end
            tick();
            faulted = fault_now;
        end
        idle_inputs();
        vectors++; if (acc_halt !== 1'b1) begin miscompares++; $display("FAIL bnd_halt: got %b want 1", acc_halt); end
        sr_read(32'h00, d);
        vectors++; if (d !== status_word(0, 1, 0, 3, ech)) begin miscompares++; $display("FAIL bnd_status: got %h want %h", d, status_word(0, 1, 0, 3, ech)); end
        sr_write(32'h00, 64'h2);
        sr_write(32'h10, 64'h0);
    endtask

    task automatic test_fault_done_reset();
        logic [63:0] d;
        sr_write(32'h08, 64'h1000);
        sr_write(32'h10, 64'h100);
        sr_write(32'h00, 64'h1);
        tick();
        acc_req_valid = 2'b10;
        acc_req_addr[64 +: 64] = 64'h200;
        mem_req_grant = 2'b11;
        acc_done = 1'b1;
        #1;
        vectors++; if (mem_req_valid !== 2'b00) begin miscompares++; $display("FAIL fd_gate: got %b want 00", mem_req_valid); end
        tick();
        idle_inputs();
        sr_read(32'h00, d);
        vectors++; if (d !== status_word(0, 1, 0, 3, 1)) begin miscompares++; $display("FAIL fd_status: got %h want %h", d, status_word(0, 1, 0, 3, 1)); end
        reset = 1'b1;
        acc_req_valid = 2'b11;
        mem_req_grant = 2'b11;
        tick();
        vectors++; if (acc_halt !== 1'b0) begin miscompares++; $display("FAIL rst2_halt: got %b want 0", acc_halt); end
        vectors++; if (acc_start !== 1'b0) begin miscompares++; $display("FAIL rst2_start: got %b want 0", acc_start); end
        vectors++; if (sr_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst2_resp_valid: got %b want 0", sr_resp_valid); end
        vectors++; if (sr_resp_data !== 64'd0) begin miscompares++; $display("FAIL rst2_resp_data: got %h want 0", sr_resp_data); end
        vectors++; if (mem_req_valid !== 2'b00) begin miscompares++; $display("FAIL rst2_mem_valid: got %b want 00", mem_req_valid); end
        vectors++; if (acc_req_grant !== 2'b00) begin miscompares++; $display("FAIL rst2_grant: got %b want 00", acc_req_grant); end
        reset = 1'b0;
        idle_inputs();
        sr_read(32'h10, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL rst2_limit: got %h want 0", d); end
        sr_read(32'h08, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL rst2_base: got %h want 0", d); end
        sr_read(32'h00, d);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL rst2_status: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_relocation();
        test_done();
        test_fault();
        test_timeout();
        test_config_lock();
        test_random();
        test_fault_done_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accel_softreg_ctrl.md
Name: accel_softreg_ctrl

Overview:
Parametrised soft-register front end for an AMI-attached accelerator (e.g. DNNWeaver). It supersedes the single-register start/cycle-count driver and generalises it in three ways: NUM_CH memory channels, a base/limit address window with bounds-fault detection, and a watchdog timeout. It also adds abort and per-channel request counters. The block sits between the softreg interface, the accelerator core and the per-app memory ports, and relocates every accelerator request into the app's window.

Parameters:
NUM_CH, 2, number of memory request channels
ADDR_W, 64, memory address width
REG_ADDR_W, 32, softreg address width
CNT_W, 64, width of cycle and request counters (≤64)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
sr_req_valid  in  1  softreg request valid
sr_req_write  in  1  1 = write, 0 = read
sr_req_addr  in  REG_ADDR_W  byte address, 8-byte aligned
sr_req_data  in  64  write data
sr_resp_valid  out  1  read response valid
sr_resp_data  out  64  read data
acc_start  out  1  one-cycle start pulse to accelerator
acc_halt  out  1  level; accelerator must stop issuing
acc_done  in  1  accelerator completion pulse
acc_req_valid  in  NUM_CH  per-channel request valid from accelerator
acc_req_addr  in  NUM_CH*ADDR_W  per-channel window-relative address, channel c at [c*ADDR_W +: ADDR_W]
acc_req_grant  out  NUM_CH  grant returned to accelerator
mem_req_valid  out  NUM_CH  request valid to memory
mem_req_addr  out  NUM_CH*ADDR_W  relocated address
mem_req_grant  in  NUM_CH  grant from memory

Behaviour:
- Register map (offset: write / read):
  - 0x00: CTRL / STATUS.
    - CTRL: bit0 start, bit1 abort, bit2 clear sticky status.
    - STATUS: bit0 done, bit1 fault, bit2 timeout, bits[5:4] state, bits[15:8] fault channel.
  - 0x08: BASE.
  - 0x10: LIMIT; 0 = unlimited.
  - 0x18: TIMEOUT in cycles; 0 = disabled.
  - 0x20: CYCLES, read-only.
  - 0x28+8*c: REQCNT[c], read-only.
  - Unmapped reads return 0. Writes to read-only or unmapped addresses are ignored.
- Reads: sr_resp_valid is asserted exactly 1 cycle after a read request, with data sampled at request time. Writes produce no response.
- Writes to BASE, LIMIT and TIMEOUT take effect only in IDLE; in any other state they are ignored.
- FSM states: IDLE=0, START=1, RUN=2, HALT=3.
  - IDLE→START: on CTRL.start write. A start write in any other state is ignored.
  - START: acc_start=1 for this cycle only. CYCLES and all REQCNT are cleared, and done/fault/timeout are cleared. Next state is RUN.
  - RUN→IDLE: on acc_done; set done.
  - RUN→HALT: on bounds fault or timeout.
  - RUN or HALT→IDLE: on CTRL.abort write or CTRL.clear write.
  - Priority in a single RUN cycle: fault > timeout > acc_done > abort.
- CYCLES increments every RUN cycle and saturates at all-ones.
- Timeout fires in the RUN cycle in which CYCLES+1 == TIMEOUT (TIMEOUT≠0); set the timeout bit.
- Relocation is combinational: mem_req_addr[c] = acc_req_addr[c] + BASE, modulo 2^ADDR_W.
- Bounds check: a fault occurs when LIMIT≠0 and acc_req_valid[c] && acc_req_addr[c] ≥ LIMIT.
  - The faulting request is never presented: mem_req_valid[c]=0 in that cycle.
  - fault is set and fault channel = lowest faulting c.
- Request gating:
  - mem_req_valid[c] = acc_req_valid[c] && state==RUN && no fault this cycle.
  - acc_req_grant[c] = mem_req_grant[c] && mem_req_valid[c].
- acc_halt = (state==HALT).
- REQCNT[c] increments when mem_req_valid[c] && mem_req_grant[c], saturating.
- CTRL.clear clears done/fault/timeout. If a start and a clear arrive in the same write, start wins: sticky bits are cleared in START anyway.
- Reset values:
  - state=IDLE.
  - All registers and counters = 0.
  - acc_start=0, acc_halt=0, sr_resp_valid=0, sr_resp_data=0, mem_req_valid=0, acc_req_grant=0.
  - Reset mid-RUN drops to IDLE the next cycle with no acc_start.

Test Plan:
- Write BASE=0x1000, then CTRL=1 → acc_start high exactly 1 cycle. acc_req_addr[1]=0x40 valid with grant → mem_req_addr[1]=0x1040. REQCNT[1] reads 1.
- Start, hold 10 RUN cycles, pulse acc_done → STATUS reads done=1, state=0. CYCLES reads 11 (acc_done cycle included). Read response arrives 1 cycle after request.
- LIMIT=0x100, channel 0 requests 0x100 → mem_req_valid[0]=0, state=HALT, acc_halt=1, STATUS fault=1, fault channel=0. CTRL abort → IDLE, acc_halt=0.
- TIMEOUT=5, acc_done never asserted → HALT entered after the 5th RUN cycle. STATUS timeout=1. CYCLES=5.
- Write BASE during RUN → value unchanged on readback. A second start during RUN is ignored: no acc_start pulse.
- Same cycle: fault on ch1 and acc_done → state=HALT, fault=1, done=0. Then reset asserted in HALT → all outputs at reset values next cycle.
